// File: rtl/load_store_unit_if.sv
// Request/response handshake between the pipeline MEM stage and the load/store unit.
// The requester holds req_* until req_ready; the unit answers with a one-cycle resp_valid pulse.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic        busy;

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_error, busy
    );

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_error, busy
    );
endinterface

// File: rtl/load_store_unit.sv
// MEM-stage load/store sequencer in front of a word-addressed data RAM: alignment and range
// checks, read-modify-write for sub-word stores, lane extraction and extension for loads.
module load_store_unit #(
    parameter int unsigned DEPTH = 21
) (
    input  logic                     clk,
    input  logic                     rst,
    load_store_unit_if.slave         lsu,
    output logic [31:0]              DMEM_address,
    output logic [31:0]              DMEM_data_in,
    output logic                     DMEM_mem_write,
    output logic                     DMEM_mem_read,
    input  logic [31:0]              DMEM_data_out
);

    typedef enum logic [2:0] {StIdle, StLoad, StRmwRd, StStore, StDone} state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q;
    logic [1:0]  size_q;
    logic        write_q;
    logic        unsigned_q;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        error_q, error_d;

    logic        accept;
    logic        req_err;
    logic [31:0] byte_sh, half_sh;
    logic [31:0] load_val;
    logic [31:0] lane_mask;
    logic [31:0] merged;

    assign accept = lsu.req_valid & lsu.req_ready;

    always_comb begin
        req_err = 1'b0;
        unique case (lsu.req_size)
            2'b00: req_err = 1'b0;
            2'b01: req_err = lsu.req_addr[0];
            2'b10: req_err = (lsu.req_addr[1:0] != 2'b00);
            2'b11: req_err = 1'b1;
        endcase
        if ({2'b00, lsu.req_addr[31:2]} >= DEPTH) begin
            req_err = 1'b1;
        end
    end

    // Lane extraction for loads; the same shifts position the store lane for the merge.
    assign byte_sh = DMEM_data_out >> {addr_q[1:0], 3'b000};
    assign half_sh = DMEM_data_out >> {addr_q[1], 4'b0000};

    always_comb begin
        load_val  = DMEM_data_out;
        lane_mask = 32'hFFFF_FFFF;
        merged    = wdata_q;
        unique case (size_q)
            2'b00: begin
                load_val  = unsigned_q ? {24'h0, byte_sh[7:0]} : {{24{byte_sh[7]}}, byte_sh[7:0]};
                lane_mask = 32'h0000_00FF << {addr_q[1:0], 3'b000};
                merged    = (DMEM_data_out & ~lane_mask) |
                            ((wdata_q & 32'h0000_00FF) << {addr_q[1:0], 3'b000});
            end
            2'b01: begin
                load_val  = unsigned_q ? {16'h0, half_sh[15:0]} : {{16{half_sh[15]}}, half_sh[15:0]};
                lane_mask = 32'h0000_FFFF << {addr_q[1], 4'b0000};
                merged    = (DMEM_data_out & ~lane_mask) |
                            ((wdata_q & 32'h0000_FFFF) << {addr_q[1], 4'b0000});
            end
            default: begin
                load_val  = DMEM_data_out;
                lane_mask = 32'hFFFF_FFFF;
                merged    = wdata_q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            size_q     <= '0;
            write_q    <= 1'b0;
            unsigned_q <= 1'b0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            error_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            error_q <= error_d;
            if (accept) begin
                addr_q     <= lsu.req_addr;
                size_q     <= lsu.req_size;
                write_q    <= lsu.req_write;
                unsigned_q <= lsu.req_unsigned;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    if (req_err) begin
                        state_d = StDone;
                    end else if (!lsu.req_write) begin
                        state_d = StLoad;
                    end else if (lsu.req_size == 2'b10) begin
                        state_d = StStore;
                    end else begin
                        state_d = StRmwRd;
                    end
                end
            end
            StLoad:  state_d = StDone;
            StRmwRd: state_d = StStore;
            StStore: state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Response registers only change on entry to DONE, so they hold between responses.
    always_comb begin
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        error_d = error_q;
        if (accept) begin
            wdata_d = lsu.req_wdata;
            if (req_err) begin
                rdata_d = '0;
                error_d = 1'b1;
            end
        end
        if (state_q == StLoad) begin
            rdata_d = load_val;
            error_d = 1'b0;
        end
        if (state_q == StRmwRd) begin
            wdata_d = merged;
        end
        if (state_q == StStore) begin
            rdata_d = '0;
            error_d = 1'b0;
        end
    end

    always_comb begin
        lsu.req_ready   = (state_q == StIdle) && !rst;
        lsu.busy        = (state_q != StIdle);
        lsu.resp_valid  = (state_q == StDone);
        lsu.resp_rdata  = rdata_q;
        lsu.resp_error  = error_q;
        DMEM_mem_read   = (state_q == StLoad) || (state_q == StRmwRd);
        DMEM_mem_write  = (state_q == StStore) && !rst;
        DMEM_data_in    = (state_q == StStore) ? wdata_q : 32'h0;
        DMEM_address    = ((state_q == StIdle) || (state_q == StDone)) ? 32'h0
                                                                        : {2'b00, addr_q[31:2]};
    end

    logic unused_write;
    assign unused_write = write_q;

endmodule
